argmax_stream: RTL and testbench
================================

# argmax_stream

Streaming arg-max unit for the classifier head of the ECG 1D-CNN. It consumes one frame of `N` class scores, one per accepted beat, over a valid/ready input stream. It emits the winning score and its class index on a valid/ready output stream. The comparison is the strict greater-than used throughout the datapath, so the first occurrence wins on ties.

## Interface
Parameters:
- `DW`, 32: score width in bits.
- `N`, 5: scores per frame (class count); legal range 1..2^IW.
- `IW`, 3: index width in bits; must satisfy 2^IW >= N.
- `SIGNED`, 1: 1 = compare as two's complement; 0 = compare as unsigned.

Ports:
- `i_clk`  in  1  clock; all logic is on the rising edge.
- `i_rst`  in  1  reset, synchronous, active-high.
- `i_data`  in  DW  score input.
- `i_valid`  in  1  `i_data` is valid.
- `o_ready`  out  1  the block can accept a score this cycle.
- `o_max`  out  DW  winning score of the last completed frame.
- `o_idx`  out  IW  position (0..N-1) of the winning score within its frame.
- `o_valid`  out  1  `o_max` and `o_idx` are valid.
- `i_ready`  in  1  the downstream block accepts the result.

## Operation
- Single clock. Reset is synchronous and active-high.
- State machine has two states: ACC and OUT.
- Reset forces state ACC with element counter `cnt`=0, running max `max_r`=0 and running index `idx_r`=0. It also sets `o_valid`=0, `o_max`=0 and `o_idx`=0.
- `o_ready` = (state==ACC) && !`i_rst`. It is derived combinationally from registered state only and never depends on `i_valid`.
- An input beat is accepted when `i_valid` && `o_ready`. No state changes on cycles without acceptance, so gaps in `i_valid` are allowed.
- ACC, accepted beat with `cnt`==0: `max_r`<=`i_data`, `idx_r`<=0. The first element is loaded unconditionally, never compared.
- ACC, accepted beat with `cnt`>0: if `i_data` > `max_r`, then `max_r`<=`i_data` and `idx_r`<=`cnt`; otherwise both hold.
  - The comparison is strict greater-than. Equal values keep the earlier index.
  - With SIGNED=1 the comparison is $signed; with SIGNED=0 it is unsigned.
- `cnt` increments on each accepted beat and wraps from N-1 to 0.
- Accepting the beat with `cnt`==N-1 completes the frame:
  - Next state is OUT.
  - `o_max`/`o_idx` are loaded with the final max/idx. This includes the current beat if it wins.
  - `o_valid`<=1 and `cnt`<=0.
- OUT: `o_max`, `o_idx` and `o_valid` hold stable until `i_valid`-independent acceptance (`o_valid` && `i_ready`). On acceptance, next state is ACC and `o_valid`<=0.
- `o_max` and `o_idx` keep their last value after `o_valid` drops. They change only when a frame completes or on reset.
- N=1: every accepted beat is a complete frame, giving `o_idx`=0 and `o_max`=`i_data`.
- Reset mid-frame or while in OUT discards any partial frame or pending result. The next accepted beat is element 0 of a new frame.

## Timing
- Input handshake to counter/max update: 1 cycle (registered).
- Last beat accepted in cycle t: `o_valid`=1 from cycle t+1.
- Output accepted in cycle u: `o_valid`=0 and `o_ready`=1 from cycle u+1. The earliest next input is accepted at u+1.
- `o_ready` is 0 for every cycle `o_valid` is 1; input and output never overlap.
- Minimum frame period is N+1 cycles, achieved with `i_valid` and `i_ready` held high.
- `i_rst` high in cycle r gives `o_ready`=0 in cycle r. In cycle r+1: `o_valid`=0, `o_max`=0, `o_idx`=0, and `o_ready`=1 unless reset is still asserted.
- No combinational path from `i_valid` or `i_data` to any output, nor from `i_ready` to `o_ready`.

## Test plan
- SIGNED=1, N=5; input 3, -1, 7, 7, 2 back-to-back with `i_ready`=1 -> one cycle after the 5th beat: `o_max`=7, `o_idx`=2, `o_valid`=1 for one cycle. `o_ready` is 0 on that cycle and 1 on the next.
- Two cases with the same configuration:
  - All five scores = -2147483648 -> `o_max`=32'h80000000, `o_idx`=0.
  - Scores -5, -4, -3, -2, -1 -> `o_max`=-1, `o_idx`=4. This covers a last-beat winner.
- Backpressure: frame 1, 9, 4, 0, 0 with `i_ready`=0 for 4 cycles after `o_valid` rises, and `i_valid` held high throughout.
  - `o_max`=9 and `o_idx`=1 stay stable and `o_ready` stays 0 for all 4 cycles.
  - The next frame's first beat is accepted exactly one cycle after the `i_ready` handshake.
- Random `i_valid` gaps (about 50% duty) across three frames -> results match a software reference, with zero dropped or duplicated beats.
- Reset mid-frame: accept 100, 50, assert `i_rst` for 1 cycle, then send frame 1, 2, 3, 4, 5 -> a single result `o_max`=5, `o_idx`=4. The value 100 never appears.
- SIGNED=0: frame 32'hFFFFFFFF, 1, 0, 2, 3 -> `o_max`=32'hFFFFFFFF, `o_idx`=0.
- N=1: beats 8 then 6 -> two results, (8, 0) then (6, 0).

Source files
------------

// File: rtl/argmax_stream.sv
// argmax_stream
//   Streaming arg-max over frames of N scores. Scores arrive one per accepted
//   beat on a valid/ready input. The winning score and its position within
//   the frame are presented on a valid/ready output once the last beat of
//   the frame has been accepted. Strict greater-than means the earliest
//   index wins a tie. SIGNED selects two's-complement or unsigned compare.
//
// Ports
//   i_clk    : clock, rising edge
//   i_rst    : synchronous active-high reset
//   i_data   : score input (DW bits)
//   i_valid  : i_data is valid
//   o_ready  : block accepts a score this cycle
//   o_max    : winning score of the last completed frame
//   o_idx    : index (0..N-1) of the winning score
//   o_valid  : o_max/o_idx are valid
//   i_ready  : downstream accepts the result
module argmax_stream #(
  parameter int DW     = 32,
  parameter int N      = 5,
  parameter int IW     = 3,
  parameter int SIGNED = 1
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic [DW-1:0] i_data,
  input  logic          i_valid,
  output logic          o_ready,
  output logic [DW-1:0] o_max,
  output logic [IW-1:0] o_idx,
  output logic          o_valid,
  input  logic          i_ready
);

  typedef enum logic {ACC, OUT} state_e;

  localparam logic [IW-1:0] LAST = IW'(N - 1);

  state_e        state_q, state_d;
  logic [IW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] max_q, max_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [DW-1:0] o_max_q, o_max_d;
  logic [IW-1:0] o_idx_q, o_idx_d;
  logic          o_valid_q, o_valid_d;

  logic in_fire;
  logic gt;
  logic win;

  assign o_ready = (state_q == ACC) && !i_rst;
  assign o_max   = o_max_q;
  assign o_idx   = o_idx_q;
  assign o_valid = o_valid_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    max_d     = max_q;
    idx_d     = idx_q;
    o_max_d   = o_max_q;
    o_idx_d   = o_idx_q;
    o_valid_d = o_valid_q;

    in_fire = i_valid && o_ready;
    if (SIGNED != 0) gt = $signed(i_data) > $signed(max_q);
    else             gt = i_data > max_q;
    // Element 0 always loads; later elements only on a strict win.
    win = (cnt_q == '0) || gt;

    case (state_q)
      ACC: begin
        if (in_fire) begin
          if (win) begin
            max_d = i_data;
            idx_d = cnt_q;
          end
          if (cnt_q == LAST) begin
            // Result is taken from the same selection the running max uses,
            // so a winning last beat is included in this frame's output.
            cnt_d     = '0;
            state_d   = OUT;
            o_max_d   = win ? i_data : max_q;
            o_idx_d   = win ? cnt_q  : idx_q;
            o_valid_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      OUT: begin
        if (i_ready) begin
          state_d   = ACC;
          o_valid_d = 1'b0;
        end
      end
      default: state_d = ACC;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= ACC;
      cnt_q     <= '0;
      max_q     <= '0;
      idx_q     <= '0;
      o_max_q   <= '0;
      o_idx_q   <= '0;
      o_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      max_q     <= max_d;
      idx_q     <= idx_d;
      o_max_q   <= o_max_d;
      o_idx_q   <= o_idx_d;
      o_valid_q <= o_valid_d;
    end
  end

endmodule

// File: tb/tb_argmax_stream.sv
// Bench for argmax_stream: three instances (signed N=5, unsigned N=5,
// signed N=1) driven from one clock and checked against a reference arg-max.
module tb_argmax_stream;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] din  [3];
  logic        vin  [3];
  logic        rdy  [3];
  logic [31:0] omax [3];
  logic [2:0]  oidx [3];
  logic        ovld [3];
  logic        ordy [3];

  int checks   = 0;
  int failures = 0;
  int rises0   = 0;
  logic prev_v0 = 1'b0;

  always #5 clk = ~clk;

  argmax_stream #(.DW(32), .N(5), .IW(3), .SIGNED(1)) u_s (
    .i_clk(clk), .i_rst(rst), .i_data(din[0]), .i_valid(vin[0]), .o_ready(rdy[0]),
    .o_max(omax[0]), .o_idx(oidx[0]), .o_valid(ovld[0]), .i_ready(ordy[0]));
  argmax_stream #(.DW(32), .N(5), .IW(3), .SIGNED(0)) u_u (
    .i_clk(clk), .i_rst(rst), .i_data(din[1]), .i_valid(vin[1]), .o_ready(rdy[1]),
    .o_max(omax[1]), .o_idx(oidx[1]), .o_valid(ovld[1]), .i_ready(ordy[1]));
  argmax_stream #(.DW(32), .N(1), .IW(3), .SIGNED(1)) u_n1 (
    .i_clk(clk), .i_rst(rst), .i_data(din[2]), .i_valid(vin[2]), .o_ready(rdy[2]),
    .o_max(omax[2]), .o_idx(oidx[2]), .o_valid(ovld[2]), .i_ready(ordy[2]));

  // Each result on u_s is presented with i_ready high except in the
  // backpressure case, so the number of o_valid rising edges is the number
  // of results produced.
  always @(negedge clk) begin
    if (ovld[0] && !prev_v0) rises0++;
    prev_v0 <= ovld[0];
  end

  typedef struct packed {
    logic [4:0][31:0] s;
    logic [31:0]      emax;
    logic [2:0]       eidx;
  } vec_t;

  vec_t tbl [3];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Reference arg-max: first index holding the largest value.
  task automatic ref_am(input logic [4:0][31:0] s, input int n, input bit sg,
                        output logic [31:0] m, output logic [2:0] ix);
    int best = 0;
    for (int i = 1; i < n; i++) begin
      if (sg ? ($signed(s[i]) > $signed(s[best])) : (s[i] > s[best])) best = i;
    end
    m  = s[best];
    ix = 3'(best);
  endtask

  // Presents one beat and returns at the negedge after it was accepted.
  task automatic send(input int s, input logic [31:0] v);
    int g = 0;
    vin[s] = 1'b1;
    din[s] = v;
    while (!rdy[s] && g < 40) begin
      @(negedge clk);
      g++;
    end
    if (!rdy[s]) begin
      checks++;
      failures++;
      $display("FAIL send_timeout inst=%0d actual=o_ready_low required=o_ready_high", s);
    end
    @(negedge clk);
    vin[s] = 1'b0;
  endtask

  // Called at the negedge right after the last beat was accepted.
  task automatic check_result(input int s, input logic [31:0] m, input logic [2:0] ix,
                              input string nm);
    chk({nm, "_valid"}, 32'(ovld[s]), 32'd1);
    chk({nm, "_max"},   omax[s], m);
    chk({nm, "_idx"},   32'(oidx[s]), 32'(ix));
    chk({nm, "_rdy_lo"}, 32'(rdy[s]), 32'd0);
    @(negedge clk);
    chk({nm, "_valid_lo"}, 32'(ovld[s]), 32'd0);
    chk({nm, "_rdy_hi"},   32'(rdy[s]), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

  initial begin
    logic [4:0][31:0] rs;
    logic [31:0] em;
    logic [2:0]  ei;

    tbl[0].s = {32'd2, 32'd7, 32'd7, 32'hFFFFFFFF, 32'd3};
    tbl[0].emax = 32'd7;        tbl[0].eidx = 3'd2;
    tbl[1].s = {5{32'h80000000}};
    tbl[1].emax = 32'h80000000; tbl[1].eidx = 3'd0;
    tbl[2].s = {32'hFFFFFFFF, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'hFFFFFFFC, 32'hFFFFFFFB};
    tbl[2].emax = 32'hFFFFFFFF; tbl[2].eidx = 3'd4;

    for (int i = 0; i < 3; i++) begin
      vin[i] = 1'b0; din[i] = '0; ordy[i] = 1'b1;
    end
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_valid", 32'(ovld[0]), 32'd0);
    chk("rst_max",   omax[0], 32'd0);
    chk("rst_idx",   32'(oidx[0]), 32'd0);
    chk("rst_rdy",   32'(rdy[0]), 32'd0);
    rst = 1'b0;
    #1;
    chk("rst_rel_rdy", 32'(rdy[0]), 32'd1);
    @(negedge clk);

    // Table: back-to-back frames on the signed instance.
    for (int i = 0; i < 3; i++) begin
      for (int b = 0; b < 5; b++) send(0, tbl[i].s[b]);
      check_result(0, tbl[i].emax, tbl[i].eidx, $sformatf("tbl%0d", i));
    end

    // Backpressure with i_valid held high carrying the next frame's first beat.
    send(0, 32'd1); send(0, 32'd9); send(0, 32'd4); send(0, 32'd0);
    vin[0] = 1'b1; din[0] = 32'd0; ordy[0] = 1'b0;
    @(negedge clk);
    din[0] = 32'd11;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("bp%0d_valid", k), 32'(ovld[0]), 32'd1);
      chk($sformatf("bp%0d_max", k),   omax[0], 32'd9);
      chk($sformatf("bp%0d_idx", k),   32'(oidx[0]), 32'd1);
      chk($sformatf("bp%0d_rdy", k),   32'(rdy[0]), 32'd0);
      @(negedge clk);
    end
    ordy[0] = 1'b1;
    @(negedge clk);
    chk("bp_rel_valid", 32'(ovld[0]), 32'd0);
    chk("bp_rel_rdy",   32'(rdy[0]), 32'd1);
    @(negedge clk);
    send(0, 32'd2); send(0, 32'd3); send(0, 32'd4); send(0, 32'd5);
    check_result(0, 32'd11, 3'd0, "bp_next");

    // Random scores with random gaps in i_valid.
    for (int f = 0; f < 3; f++) begin
      for (int b = 0; b < 5; b++) begin
        rs[b] = $urandom;
        if ($urandom_range(0, 3) == 0) rs[b] = rs[0];
      end
      for (int b = 0; b < 5; b++) begin
        while ($urandom_range(0, 1) == 1) begin
          vin[0] = 1'b0;
          @(negedge clk);
        end
        send(0, rs[b]);
      end
      ref_am(rs, 5, 1'b1, em, ei);
      check_result(0, em, ei, $sformatf("rnd%0d", f));
    end

    // Reset mid-frame discards the partial frame.
    send(0, 32'd100); send(0, 32'd50);
    rst = 1'b1;
    #1;
    chk("mid_rst_rdy", 32'(rdy[0]), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(ovld[0]), 32'd0);
    chk("mid_rst_max",   omax[0], 32'd0);
    chk("mid_rst_idx",   32'(oidx[0]), 32'd0);
    chk("mid_rst_rdy1",  32'(rdy[0]), 32'd1);
    @(negedge clk);
    for (int b = 1; b <= 5; b++) send(0, 32'(b));
    check_result(0, 32'd5, 3'd4, "post_rst");

    // Unsigned compare: all-ones is the largest value.
    send(1, 32'hFFFFFFFF); send(1, 32'd1); send(1, 32'd0); send(1, 32'd2); send(1, 32'd3);
    check_result(1, 32'hFFFFFFFF, 3'd0, "uns");

    // N=1: each beat is a frame.
    send(2, 32'd8);
    check_result(2, 32'd8, 3'd0, "n1_a");
    send(2, 32'd6);
    check_result(2, 32'd6, 3'd0, "n1_b");

    @(negedge clk);
    chk("result_count", 32'(rises0), 32'd9);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
